param_load_store_regfile: RTL

- Parametrised successor to the single n-bit load/store register in the accumulator datapath.
- Holds NUM_REGS registers, each WIDTH bits, selected by an index.
- Supports load, store, set, add, subtract, increment, and multi-cycle logical shifts, with zero/carry flags and a start/busy/done handshake toward the control unit.

---
 rtl/param_load_store_regfile_if.sv | 33 +++
 rtl/param_load_store_regfile.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/param_load_store_regfile_if.sv
// ----------------------------------------------------------------------------
// param_load_store_regfile_if
// Command/response bundle between the control unit and the register file.
//   master (control unit) drives : set, start, op, sel, d, shamt
//   slave  (register file) drives: q, busy, done, zero, carry
// ----------------------------------------------------------------------------
interface param_load_store_regfile_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2,
    parameter int SH_W  = 4
) ();
    logic             set;
    logic             start;
    logic [2:0]       op;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] d;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             zero;
    logic             carry;

    modport master (
        output set, start, op, sel, d, shamt,
        input  q, busy, done, zero, carry
    );

    modport slave (
        input  set, start, op, sel, d, shamt,
        output q, busy, done, zero, carry
    );
endinterface

// File: rtl/param_load_store_regfile.sv
// ----------------------------------------------------------------------------
// param_load_store_regfile
// NUM_REGS x WIDTH register file for the accumulator datapath. Executes
// LOAD/STORE/ADD/SUB/INC in one cycle and logical shifts one bit per cycle,
// reporting zero/carry flags and a start/busy/done handshake.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-high reset, clears every register and flag
//   bus    command/response interface (slave side):
//          set/start/op/sel/d/shamt in, q/busy/done/zero/carry out
// WIDTH is expected to be at least 2.
// ----------------------------------------------------------------------------
module param_load_store_regfile #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = 2,
    parameter int SH_W     = 4
) (
    input logic                        clock,
    input logic                        reset,
    param_load_store_regfile_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_INC   = 3'b101;
    localparam logic [2:0] OP_SHL   = 3'b110;
    localparam logic [2:0] OP_SHR   = 3'b111;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];
    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SEL_W-1:0] sh_sel_q, sh_sel_d;
    logic             sh_left_q, sh_left_d;

    logic             sel_ok;
    logic [WIDTH-1:0] cmd_rd;
    logic [WIDTH-1:0] sh_rd;
    logic [CNT_W-1:0] shamt_cl;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH:0]   inc_ext;

    logic             wr_en;
    logic [SEL_W-1:0] wr_idx;
    logic [WIDTH-1:0] wr_data;

    // Read ports: one for the incoming command, one for the shift in flight.
    // Indices beyond NUM_REGS read as zero and are never written.
    always_comb begin
        cmd_rd = '0;
        sh_rd  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (SEL_W'(i) == bus.sel)  cmd_rd = regs_q[i];
            if (SEL_W'(i) == sh_sel_q) sh_rd  = regs_q[i];
        end
    end

    always_comb begin
        sel_ok = (int'(bus.sel) < NUM_REGS);
        // Shifting by more than WIDTH gives the same result as WIDTH.
        if (int'(bus.shamt) > WIDTH) begin
            shamt_cl = CNT_W'(WIDTH);
        end else begin
            shamt_cl = CNT_W'(bus.shamt);
        end
        sum_ext  = {1'b0, cmd_rd} + {1'b0, bus.d};
        // Bit WIDTH of the extended difference is the borrow (d > reg).
        diff_ext = {1'b0, cmd_rd} - {1'b0, bus.d};
        inc_ext  = {1'b0, cmd_rd} + (WIDTH + 1)'(1);
    end

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        done_d    = 1'b0;
        zero_d    = zero_q;
        carry_d   = carry_q;
        count_d   = count_q;
        sh_sel_d  = sh_sel_q;
        sh_left_d = sh_left_q;
        wr_en     = 1'b0;
        wr_idx    = bus.sel;
        wr_data   = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.set) begin
                    // set wins over start and touches neither flags nor done.
                    wr_en   = sel_ok;
                    wr_data = '1;
                end else if (bus.start) begin
                    done_d = 1'b1;
                    if (sel_ok) begin
                        case (bus.op)
                            OP_LOAD: begin
                                wr_en   = 1'b1;
                                wr_data = bus.d;
                                zero_d  = (bus.d == '0);
                            end
                            OP_STORE: begin
                                q_d = cmd_rd;
                            end
                            OP_ADD: begin
                                wr_en   = 1'b1;
                                wr_data = sum_ext[WIDTH-1:0];
                                carry_d = sum_ext[WIDTH];
                                zero_d  = (sum_ext[WIDTH-1:0] == '0);
                            end
                            OP_SUB: begin
                                wr_en   = 1'b1;
                                wr_data = diff_ext[WIDTH-1:0];
                                carry_d = diff_ext[WIDTH];
                                zero_d  = (diff_ext[WIDTH-1:0] == '0);
                            end
                            OP_INC: begin
                                wr_en   = 1'b1;
                                wr_data = inc_ext[WIDTH-1:0];
                                carry_d = inc_ext[WIDTH];
                                zero_d  = (inc_ext[WIDTH-1:0] == '0);
                            end
                            OP_SHL, OP_SHR: begin
                                if (shamt_cl == '0) begin
                                    // Zero-length shift completes like a single-cycle op.
                                    carry_d = 1'b0;
                                    zero_d  = (cmd_rd == '0);
                                end else begin
                                    done_d    = 1'b0;
                                    state_d   = ST_SHIFT;
                                    count_d   = shamt_cl;
                                    sh_sel_d  = bus.sel;
                                    sh_left_d = (bus.op == OP_SHL);
                                end
                            end
                            default: ; // OP_NOP
                        endcase
                    end
                end
            end
            default: begin
                // ST_SHIFT: one bit per cycle; all bus inputs are ignored here.
                wr_en  = 1'b1;
                wr_idx = sh_sel_q;
                if (sh_left_q) begin
                    wr_data = sh_rd << 1;
                    carry_d = sh_rd[WIDTH-1];
                end else begin
                    wr_data = sh_rd >> 1;
                    carry_d = sh_rd[0];
                end
                zero_d  = (wr_data == '0);
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en && (SEL_W'(i) == wr_idx)) regs_d[i] = wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            q_q       <= '0;
            done_q    <= 1'b0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            count_q   <= '0;
            sh_sel_q  <= '0;
            sh_left_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            regs_q    <= regs_d;
            q_q       <= q_d;
            done_q    <= done_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            count_q   <= count_d;
            sh_sel_q  <= sh_sel_d;
            sh_left_q <= sh_left_d;
        end
    end

    assign bus.q     = q_q;
    assign bus.busy  = (state_q == ST_SHIFT);
    assign bus.done  = done_q;
    assign bus.zero  = zero_q;
    assign bus.carry = carry_q;

endmodule
